// File: rtl/ia_pack_pkg.sv
// Shared sizing, FSM states and the sparse IA bundle layout used by the packer and the PE input side.
// The iteration helper turns a packed length into intersection-unit iterations minus one.
package ia_pack_pkg;

    localparam int CHANNELS = 32;
    localparam int DATA_W   = 16;
    localparam int CIDX_W   = 8;
    localparam int LANES    = 4;
    localparam int AIM_W    = 32;

    localparam int LEN_W = $clog2(CHANNELS) + 1;
    localparam int PTR_W = $clog2(CHANNELS);
    localparam int OFF_W = $clog2(LANES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } pack_state_t;

    typedef logic signed [CHANNELS-1:0][DATA_W-1:0] ia_data_t;
    typedef logic        [CHANNELS-1:0][CIDX_W-1:0] ia_cidx_t;

    typedef struct packed {
        ia_data_t         data;
        ia_cidx_t         c_idx;
        logic [LEN_W-1:0] len;
        logic [LEN_W-1:0] iters;
    } ia_bundle_t;

    function automatic logic [LEN_W-1:0] calc_iters(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] len_m1;
        if (len == '0) begin
            return '0;
        end
        len_m1 = len - 1'b1;
        return LEN_W'(len_m1 / AIM_W);
    endfunction

endpackage

// File: rtl/ia_sparse_packer_lane_compactor.sv
// Combinational per-scan-cycle compactor: keep flags, exclusive prefix offsets, popcount, channel ids.
// With IA_PACK_RELU_EN defined, negative entries are dropped like zeros.
module lane_compactor #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int CIDX_W = 8,
    parameter int OFF_W  = $clog2(LANES) + 1
) (
    input  logic [LANES-1:0][DATA_W-1:0] i_vals,
    input  logic [CIDX_W-1:0]            i_base,
    output logic [LANES-1:0]             o_keep,
    output logic [LANES-1:0][OFF_W-1:0]  o_off,
    output logic [LANES-1:0][CIDX_W-1:0] o_cidx,
    output logic [OFF_W-1:0]             o_cnt
);

    logic [OFF_W-1:0] w_run;

    always_comb begin
        w_run  = '0;
        o_keep = '0;
        o_off  = '0;
        o_cidx = '0;
        for (int l = 0; l < LANES; l++) begin
`ifdef IA_PACK_RELU_EN
            o_keep[l] = (i_vals[l] != '0) && !i_vals[l][DATA_W-1];
`else
            o_keep[l] = (i_vals[l] != '0);
`endif
            o_off[l]  = w_run;
            o_cidx[l] = i_base + CIDX_W'(l);
            if (o_keep[l]) begin
                w_run = w_run + 1'b1;
            end
        end
        o_cnt = w_run;
    end

endmodule

// File: rtl/ia_sparse_packer.sv
// Dense-to-sparse IA packer: scans LANES entries per cycle, packs nonzeros, holds the bundle on valid/ready.
// Start to o_valid is CHANNELS/LANES+1 cycles; IA_PACK_RELU_EN fuses ReLU by dropping negative entries.
module ia_sparse_packer
    import ia_pack_pkg::*;
(
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_start,
    input  logic signed [CHANNELS-1:0][DATA_W-1:0] i_dense,
    input  logic                                  i_ready,
    output logic                                  o_busy,
    output logic                                  o_valid,
    output logic signed [CHANNELS-1:0][DATA_W-1:0] o_ia_data,
    output logic        [CHANNELS-1:0][CIDX_W-1:0] o_ia_c_idx,
    output logic [LEN_W-1:0]                      o_ia_len,
    output logic [LEN_W-1:0]                      o_ia_iters,
    output logic                                  o_finish
);

    pack_state_t      r_state;
    ia_data_t         r_buf;
    ia_bundle_t       r_bundle;
    logic [PTR_W-1:0] r_ptr;
    logic [LEN_W-1:0] r_wr;
    logic             r_busy;
    logic             r_valid;
    logic             r_finish;

    logic [LANES-1:0][DATA_W-1:0] w_lane_vals;
    logic [LANES-1:0]             w_keep;
    logic [LANES-1:0][OFF_W-1:0]  w_off;
    logic [LANES-1:0][CIDX_W-1:0] w_cidx;
    logic [OFF_W-1:0]             w_cnt;
    logic [LANES-1:0][PTR_W-1:0]  w_slot;
    logic [LEN_W-1:0]             w_wr_next;
    logic                         w_last;

    // A kept lane can never land past the last slot, so truncating the slot index is safe.
    always_comb begin
        w_lane_vals = '0;
        w_slot      = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane_vals[l] = r_buf[r_ptr + PTR_W'(l)];
            w_slot[l]      = PTR_W'(r_wr + LEN_W'(w_off[l]));
        end
    end

    assign w_wr_next = r_wr + LEN_W'(w_cnt);
    assign w_last    = (r_ptr == PTR_W'(CHANNELS - LANES));

    lane_compactor #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .CIDX_W (CIDX_W),
        .OFF_W  (OFF_W)
    ) u_compactor (
        .i_vals (w_lane_vals),
        .i_base (CIDX_W'(r_ptr)),
        .o_keep (w_keep),
        .o_off  (w_off),
        .o_cidx (w_cidx),
        .o_cnt  (w_cnt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_buf    <= '0;
            r_bundle <= '0;
            r_ptr    <= '0;
            r_wr     <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_buf    <= i_dense;
                        r_bundle <= '0;
                        r_ptr    <= '0;
                        r_wr     <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (w_keep[l]) begin
                            r_bundle.data[w_slot[l]]  <= w_lane_vals[l];
                            r_bundle.c_idx[w_slot[l]] <= w_cidx[l];
                        end
                    end
                    r_wr  <= w_wr_next;
                    r_ptr <= r_ptr + PTR_W'(LANES);
                    if (w_last) begin
                        r_bundle.len   <= w_wr_next;
                        r_bundle.iters <= calc_iters(w_wr_next);
                        r_state        <= HOLD;
                    end
                end
                HOLD: begin
                    // First HOLD cycle lets len/iters settle before the bundle is offered.
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                    end else if (i_ready) begin
                        r_valid  <= 1'b0;
                        r_finish <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_valid    = r_valid;
    assign o_finish   = r_finish;
    assign o_ia_data  = r_bundle.data;
    assign o_ia_c_idx = r_bundle.c_idx;
    assign o_ia_len   = r_bundle.len;
    assign o_ia_iters = r_bundle.iters;

endmodule
